// File: rtl/scan_test_ctrl_pkg.sv
// scan_pkg: shared types and helpers for the scan test sequencer.
//   scan_state_e  - sequencer state encoding
//   CHAIN_LEN_DEF / CNT_W_DEF - default chain length and counter width
//   scan_cmp_pass - masked response compare, operands zero-extended to SCAN_MAX_W
package scan_pkg;

  localparam int CHAIN_LEN_DEF = 2;
  localparam int CNT_W_DEF     = 8;
  localparam int SCAN_MAX_W    = 64;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_e;

  // A bit fails only if it is cared about and differs; an empty mask always passes.
  function automatic logic scan_cmp_pass(input logic [SCAN_MAX_W-1:0] resp,
                                         input logic [SCAN_MAX_W-1:0] expct,
                                         input logic [SCAN_MAX_W-1:0] mask);
    return ((resp ^ expct) & mask) == '0;
  endfunction

endpackage

// File: rtl/scan_test_ctrl_if.sv
// scan_test_ctrl_if: request/result and scan-pin bundle of the scan sequencer.
//   slave  - sequencer side: takes start/pattern/expected/mask/scan_out,
//            drives scan_en/scan_in/busy/done/pass/response/pat_cnt/fail_cnt
//   master - pattern source / chain side (mirror of slave)
interface scan_test_ctrl_if
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) ();

  logic                 start;
  logic [CHAIN_LEN-1:0] pattern_in;
  logic [CHAIN_LEN-1:0] expected_in;
  logic [CHAIN_LEN-1:0] mask_in;
  logic                 scan_out;
  logic                 scan_en;
  logic                 scan_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CHAIN_LEN-1:0] response;
  logic [CNT_W-1:0]     pat_cnt;
  logic [CNT_W-1:0]     fail_cnt;

  modport slave (
    input  start, pattern_in, expected_in, mask_in, scan_out,
    output scan_en, scan_in, busy, done, pass, response, pat_cnt, fail_cnt
  );

  modport master (
    output start, pattern_in, expected_in, mask_in, scan_out,
    input  scan_en, scan_in, busy, done, pass, response, pat_cnt, fail_cnt
  );

endinterface

// File: rtl/scan_test_ctrl_shift_cnt.sv
// scan_shift_cnt: loadable down-counter marking the last cycle of a shift phase.
//   clk, rst  - clock, async active-high reset
//   load_i    - load LOAD_VAL (phase entry)
//   en_i      - count down; holds at zero
//   last_o    - counter is zero, i.e. current cycle is the final shift
module scan_shift_cnt #(
  parameter int W        = 2,
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [W-1:0] LOAD_V = W'(LOAD_VAL);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt_q <= '0;
    else if (load_i)              cnt_q <= LOAD_V;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: single-chain scan sequencer. On start it shifts a pattern in
// MSB-first, runs one capture cycle, unloads the response, compares it with
// the expected value under a care mask and keeps pass/fail counters.
//   clk, rst - clock, async active-high reset
//   bus      - scan_test_ctrl_if.slave (request, result, counters, scan pins)
// Every output is a register; nothing combinational reaches the pins.
module scan_test_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  scan_test_ctrl_if.slave  bus
);

  localparam int CW = $clog2(CHAIN_LEN + 1);

  scan_state_e          state_q, state_d;
  logic [CHAIN_LEN-1:0] pat_sr_q, pat_sr_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CNT_W-1:0]     pat_cnt_q, pat_cnt_d;
  logic [CNT_W-1:0]     fail_cnt_q, fail_cnt_d;

  logic                  cnt_load, cnt_en, cnt_last;
  logic [CHAIN_LEN-1:0]  resp_next;
  logic                  pass_next;
  logic [SCAN_MAX_W-1:0] r64, e64, m64;

  scan_shift_cnt #(.W(CW), .LOAD_VAL(CHAIN_LEN - 1)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    pat_sr_d   = pat_sr_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    sr_d       = sr_q;
    resp_d     = resp_q;
    scan_en_d  = scan_en_q;
    scan_in_d  = scan_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    pat_cnt_d  = pat_cnt_q;
    fail_cnt_d = fail_cnt_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    // scan_out is sampled before the chain moves, so the final sample lands in
    // the LSB at the same edge that enters DONE; compare on that value.
    resp_next    = sr_q << 1;
    resp_next[0] = bus.scan_out;
    r64 = '0; e64 = '0; m64 = '0;
    r64[CHAIN_LEN-1:0] = resp_next;
    e64[CHAIN_LEN-1:0] = exp_q;
    m64[CHAIN_LEN-1:0] = mask_q;
    pass_next = scan_cmp_pass(r64, e64, m64);

    case (state_q)
      IDLE: begin
        scan_en_d = 1'b0;
        scan_in_d = 1'b0;
        if (bus.start) begin
          // First bit goes out on the accepting edge; the rest queue MSB-first.
          pat_sr_d  = bus.pattern_in << 1;
          exp_d     = bus.expected_in;
          mask_d    = bus.mask_in;
          scan_en_d = 1'b1;
          scan_in_d = bus.pattern_in[CHAIN_LEN-1];
          busy_d    = 1'b1;
          cnt_load  = 1'b1;
          state_d   = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          scan_en_d = 1'b0;
          scan_in_d = 1'b0;
          state_d   = CAPTURE;
        end else begin
          scan_in_d = pat_sr_q[CHAIN_LEN-1];
          pat_sr_d  = pat_sr_q << 1;
        end
      end
      CAPTURE: begin
        scan_en_d = 1'b1;
        scan_in_d = 1'b0;
        cnt_load  = 1'b1;
        state_d   = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        cnt_en = 1'b1;
        sr_d   = resp_next;
        if (cnt_last) begin
          scan_en_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          resp_d    = resp_next;
          pass_d    = pass_next;
          pat_cnt_d = pat_cnt_q + 1'b1;
          if (!pass_next && fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pat_sr_q   <= '0;
      exp_q      <= '0;
      mask_q     <= '0;
      sr_q       <= '0;
      resp_q     <= '0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      pat_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pat_sr_q   <= pat_sr_d;
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      sr_q       <= sr_d;
      resp_q     <= resp_d;
      scan_en_q  <= scan_en_d;
      scan_in_q  <= scan_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      pat_cnt_q  <= pat_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.scan_en  = scan_en_q;
  assign bus.scan_in  = scan_in_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.response = resp_q;
  assign bus.pat_cnt  = pat_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;

endmodule
